mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the fetch stage (IF) and the memory stage (LS, loads and stores).
- Sits between the pipeline and the memory macro.
- Holds the port for the memory's fixed read latency and returns read data to the requester that owns the access.
- Raises a stall to the fetch/hazard logic whenever fetch loses the port.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MEM_LAT, 2, memory read latency in cycles, legal range 1..4.
- STARVE_MAX, 4, number of consecutive lost arbitrations after which IF gets priority.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  fetch read data.
- ls_req  in  1  load/store request; held until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_be  in  DATA_W/8  store byte enables.
- ls_gnt  out  1  load/store request accepted this cycle.
- ls_rvalid  out  1  one-cycle pulse; ls_rdata is valid (loads only).
- ls_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en read cycle.
- arb_stall  out  1  equals if_req & ~if_gnt; fed to fetch_stall OR-logic.

Behaviour:
- State machine with states IDLE, RD_IF, RD_LS. It also keeps:
  - a latency counter cnt (3 bits);
  - a starvation counter starve (3 bits, saturating at STARVE_MAX).
- Arbitration is combinational. It happens in any cycle the port is "free", meaning state==IDLE, or state is RD_* with cnt==1 (the return cycle).
- Winner selection when the port is free:
  - Only one request present: that request wins.
  - Both present: LS wins, unless starve==STARVE_MAX, in which case IF wins.
- Grant cycle T:
  - Winner's gnt=1, mem_en=1.
  - mem_addr, mem_we, mem_wdata and mem_be are muxed from the winner.
  - IF grants drive mem_we=0 and mem_be=all ones.
- When no grant: mem_en=0 and mem_we=0. mem_addr, mem_wdata and mem_be hold the LS values (don't-care).
- Load or fetch grant: next state RD_LS or RD_IF, cnt loaded with MEM_LAT.
- Each cycle in RD_*: cnt decrements. At cnt==1 (cycle T+MEM_LAT), the matching rvalid=1 and rdata=mem_rdata (pass-through).
- After the cnt==1 cycle, next state is IDLE unless a new read is granted in that same cycle.
- Store grant: single cycle. No rvalid, state stays or returns to IDLE. A store may be granted in a return cycle.
- if_rdata and ls_rdata always carry mem_rdata; only the rvalid pulses qualify them.
- starve updates:
  - Reset to 0 on every IF grant.
  - Incremented (saturating) in any free cycle where if_req=1 and LS won.
  - Otherwise held.
- Back-to-back reads are fully pipelined for MEM_LAT=1: one grant per cycle. For MEM_LAT=N the port accepts one read every N cycles.
- Requests are assumed stable while pending. A dropped request without grant is simply ignored; there is no abort of an in-flight read.
- Reset (asynchronous, any time, including mid-read):
  - state=IDLE, cnt=0, starve=0.
  - All gnt and rvalid outputs are 0, mem_en=0, mem_we=0, arb_stall follows if_req.
  - No rvalid is ever produced for a read granted before reset.
- Simultaneous events: the rvalid of the old read and the gnt of a new request in the same cycle are legal and expected.

Test Plan:
- MEM_LAT=2, IF-only read:
  - Stimulus: if_req=1, if_addr=0x100, at cycle 0; mem_rdata=0xDEADBEEF at cycle 2.
  - Required: if_gnt=1 and mem_en=1 with mem_addr=0x100 at cycle 0; if_rvalid=1 with if_rdata=0xDEADBEEF at cycle 2 only; arb_stall=0.
- Contention:
  - Stimulus: if_req and ls_req (load, 0x2000) both asserted at cycle 0.
  - Required: ls_gnt at cycle 0; arb_stall=1 in cycles 0–1; ls_rvalid at cycle 2; if_gnt in the same cycle 2; if_rvalid at cycle 4.
- Store:
  - Stimulus: ls_we=1, ls_addr=0x40, ls_wdata=0x12345678, ls_be=4'b0011, in IDLE.
  - Required: one cycle with mem_en=1, mem_we=1, mem_be=0011; no ls_rvalid; an IF request in the next cycle is granted immediately.
- Starvation:
  - Stimulus: MEM_LAT=1, if_req held high, ls_req loads every cycle.
  - Required: LS wins 4 consecutive cycles; IF granted on the 5th; starve returns to 0.
- Reset mid-read:
  - Stimulus: assert reset at cycle 1 of a MEM_LAT=2 fetch.
  - Required: all outputs go low asynchronously; no if_rvalid at cycle 2; a fresh request after reset deassertion is granted in its first cycle.
- MEM_LAT=1 streaming:
  - Stimulus: IF-only reads for 8 consecutive cycles.
  - Required: 8 grants and 8 rvalids, each rvalid exactly 1 cycle after its grant, with no gaps.

Source files
------------

// File: rtl/mem_port_arbiter.sv
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                arb_stall
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_LS} state_e;

  localparam logic [2:0] LAT_C    = 3'(MEM_LAT);
  localparam logic [2:0] STARVE_C = 3'(STARVE_MAX);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] starve_q, starve_d;

  logic port_free;
  logic pick_if;
  logic pick_ls;

  // Grants are gated by reset so nothing is accepted while reset is held.
  always_comb begin
    port_free = (state_q == IDLE) || (cnt_q == 3'd1);
    pick_ls   = ~reset && port_free && ls_req && (~if_req || (starve_q != STARVE_C));
    pick_if   = ~reset && port_free && if_req && ~pick_ls;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    if (state_q != IDLE) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) state_d = IDLE;
    end
    // A new read granted in the return cycle overrides the return to IDLE.
    if (pick_if) begin
      state_d = RD_IF;
      cnt_d   = LAT_C;
    end else if (pick_ls && !ls_we) begin
      state_d = RD_LS;
      cnt_d   = LAT_C;
    end
    if (pick_if) begin
      starve_d = '0;
    end else if (pick_ls && if_req && (starve_q != STARVE_C)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_comb begin
    if_gnt    = pick_if;
    ls_gnt    = pick_ls;
    mem_en    = pick_if | pick_ls;
    mem_we    = pick_ls & ls_we;
    mem_addr  = pick_if ? if_addr : ls_addr;
    mem_wdata = ls_wdata;
    mem_be    = pick_if ? '1 : ls_be;
    if_rvalid = (state_q == RD_IF) && (cnt_q == 3'd1);
    ls_rvalid = (state_q == RD_LS) && (cnt_q == 3'd1);
    if_rdata  = mem_rdata;
    ls_rdata  = mem_rdata;
    arb_stall = if_req & ~pick_if;
  end

endmodule
